// File: rtl/gate_sweep_checker.sv
// Exhaustive truth-table sweep of a small combinational gate: steps through every
// input vector, holds each for DWELL cycles, samples the gate output and counts mismatches.
module gate_sweep_checker #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 10,
    parameter int unsigned GRAY  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [(1<<N)-1:0]    expect_tt,
    input  logic                 dut_z,
    output logic [N-1:0]         vec,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N:0]           err_cnt,
    output logic [N-1:0]         first_err_vec
);

    localparam int unsigned NV = 1 << N;
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned EW = N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NV-1:0]   tt_q, tt_d;
    logic [N-1:0]    vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_q, err_d;
    logic [N-1:0]    ferr_q, ferr_d;

    // Map the sweep index onto the driven vector (binary or reflected Gray order)
    function automatic logic [N-1:0] vec_of(input logic [N-1:0] i);
        return (GRAY != 0) ? (i ^ (i >> 1)) : i;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        vec_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = pass_q;
        err_d   = err_q;
        ferr_d  = ferr_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    tt_d    = expect_tt;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = '0;
                    ferr_d  = '0;
                    vec_d   = vec_of('0);
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                vec_d  = vec_q;
                if (cnt_q == CW'(DWELL - 1)) begin
                    // Sample point: the gate has had DWELL-1 cycles to settle
                    if (dut_z != tt_q[vec_q]) begin
                        if (err_q != EW'(NV)) begin
                            err_d = err_q + EW'(1);
                        end
                        if (err_q == '0) begin
                            ferr_d = vec_q;
                        end
                    end
                    if (idx_q == N'(NV - 1)) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        vec_d   = '0;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + N'(1);
                        cnt_d = '0;
                        vec_d = vec_of(idx_q + N'(1));
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            ferr_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ferr_q  <= ferr_d;
        end
    end

    assign vec           = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_q;
    assign first_err_vec = ferr_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a 2-input binary sweep instance and a
// 3-input Gray sweep instance, checked per cycle and per sweep result.
module tb_gate_sweep_checker;

    localparam int NA = 4;   // vectors, instance A (N=2)
    localparam int DA = 4;
    localparam int NB = 8;   // vectors, instance B (N=3)
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_a = 1'b0;
    logic [3:0] expect_a = '0;
    logic       dut_z_a;
    logic [1:0] vec_a;
    logic       busy_a, done_a, pass_a;
    logic [2:0] err_a;
    logic [1:0] first_a;

    logic       start_b = 1'b0;
    logic [7:0] expect_b = '0;
    logic       dut_z_b;
    logic [2:0] vec_b;
    logic       busy_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [2:0] first_b;

    logic [3:0] fn_a = 4'b0111;
    logic [7:0] fn_b = '0;
    int         dly_a = 0;
    logic [1:0] sr_a [8];

    typedef struct { int vec; bit busy; bit done; } tr_t;
    typedef struct { int err; int first; bit pass; } res_t;

    tr_t  tr_a[$], tr_b[$];
    res_t res_a[$], res_b[$];
    bit   pend_a = 0, pend_b = 0;
    bit   exp_pass_a, exp_pass_b;

    int checks = 0;
    int errors = 0;

    int ord_a[4] = '{0, 1, 2, 3};
    int ord_b[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    gate_sweep_checker #(.N(2), .DWELL(DA), .GRAY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .expect_tt(expect_a),
        .dut_z(dut_z_a), .vec(vec_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .first_err_vec(first_a)
    );

    gate_sweep_checker #(.N(3), .DWELL(DB), .GRAY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .expect_tt(expect_b),
        .dut_z(dut_z_b), .vec(vec_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .first_err_vec(first_b)
    );

    always #5 clk = ~clk;

    // Gate models: A can see its stimulus through a delay line, B is instantaneous
    always @(posedge clk) begin
        for (int i = 7; i > 0; i--) sr_a[i] <= sr_a[i-1];
        sr_a[0] <= vec_a;
    end

    always_comb begin
        if (dly_a == 0) dut_z_a = fn_a[vec_a];
        else            dut_z_a = fn_a[sr_a[dly_a-1]];
    end

    assign dut_z_b = fn_b[vec_b];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: vector k is sampled DWELL-1 cycles after it appears; a
    // delayed gate then reflects whichever vector was on the bus d cycles earlier.
    function automatic res_t model(input bit is_b, input logic [7:0] tt,
                                   input logic [7:0] fn, input int d);
        res_t r;
        int nv, dw, p, sv, v;
        nv = is_b ? NB : NA;
        dw = is_b ? DB : DA;
        r.err = 0;
        r.first = -1;
        for (int k = 0; k < nv; k++) begin
            p  = k * dw + dw - 1 - d;
            sv = (p < 0) ? 0 : (is_b ? ord_b[p / dw] : ord_a[p / dw]);
            v  = is_b ? ord_b[k] : ord_a[k];
            if (fn[sv] != tt[v]) begin
                r.err++;
                if (r.first < 0) r.first = v;
            end
        end
        if (r.first < 0) r.first = 0;
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic issue_a(input logic [3:0] tt);
        res_a.push_back(model(1'b0, {4'b0, tt}, {4'b0, fn_a}, dly_a));
        for (int k = 0; k < NA; k++)
            for (int j = 0; j < DA; j++) tr_a.push_back('{ord_a[k], 1'b1, 1'b0});
        tr_a.push_back('{0, 1'b0, 1'b1});
    endtask

    task automatic issue_b(input logic [7:0] tt);
        res_b.push_back(model(1'b1, tt, fn_b, 0));
        for (int k = 0; k < NB; k++)
            for (int j = 0; j < DB; j++) tr_b.push_back('{ord_b[k], 1'b1, 1'b0});
        tr_b.push_back('{0, 1'b0, 1'b1});
    endtask

    always @(negedge clk) begin
        tr_t t;
        res_t r;
        if (tr_a.size() > 0) begin
            t = tr_a.pop_front();
            check("a_vec", int'(vec_a), t.vec);
            check("a_busy", int'(busy_a), int'(t.busy));
            check("a_done", int'(done_a), int'(t.done));
        end else begin
            check("a_idle_busy", int'(busy_a), 0);
            check("a_idle_done", int'(done_a), 0);
        end
        if (pend_a) begin
            check("a_pass", int'(pass_a), int'(exp_pass_a));
            pend_a = 0;
        end
        if (done_a === 1'b1) begin
            check("a_res_avail", int'(res_a.size() > 0), 1);
            if (res_a.size() > 0) begin
                r = res_a.pop_front();
                check("a_err_cnt", int'(err_a), r.err);
                check("a_first_err", int'(first_a), r.first);
                exp_pass_a = r.pass;
                pend_a = 1;
            end
        end
    end

    always @(negedge clk) begin
        tr_t t;
        res_t r;
        if (tr_b.size() > 0) begin
            t = tr_b.pop_front();
            check("b_vec", int'(vec_b), t.vec);
            check("b_busy", int'(busy_b), int'(t.busy));
            check("b_done", int'(done_b), int'(t.done));
        end else begin
            check("b_idle_busy", int'(busy_b), 0);
            check("b_idle_done", int'(done_b), 0);
        end
        if (pend_b) begin
            check("b_pass", int'(pass_b), int'(exp_pass_b));
            pend_b = 0;
        end
        if (done_b === 1'b1) begin
            check("b_res_avail", int'(res_b.size() > 0), 1);
            if (res_b.size() > 0) begin
                r = res_b.pop_front();
                check("b_err_cnt", int'(err_b), r.err);
                check("b_first_err", int'(first_b), r.first);
                exp_pass_b = r.pass;
                pend_b = 1;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((tr_a.size() > 0 || tr_b.size() > 0 || res_a.size() > 0 ||
                res_b.size() > 0 || pend_a || pend_b) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain_timeout", int'(n < 500), 1);
    endtask

    task automatic sweep_a(input logic [3:0] tt, input bit pulse_mid);
        repeat (6) @(negedge clk);
        expect_a = tt;
        start_a  = 1'b1;
        @(posedge clk);
        issue_a(tt);
        @(negedge clk);
        start_a = 1'b0;
        if (pulse_mid) begin
            repeat (4) @(negedge clk);
            expect_a = ~tt;
            start_a  = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
        end
        drain();
    endtask

    task automatic sweep_b(input logic [7:0] tt);
        repeat (4) @(negedge clk);
        expect_b = tt;
        start_b  = 1'b1;
        @(posedge clk);
        issue_b(tt);
        @(negedge clk);
        start_b = 1'b0;
        drain();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vec"},   int'(vec_a),   0);
        check({tag, "_busy"},  int'(busy_a),  0);
        check({tag, "_done"},  int'(done_a),  0);
        check({tag, "_pass"},  int'(pass_a),  0);
        check({tag, "_err"},   int'(err_a),   0);
        check({tag, "_first"}, int'(first_a), 0);
    endtask

    initial begin
        #1;
        check_zero_outputs("reset");
        check("reset_b_err", int'(err_b), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Ideal NAND, then stuck-at-1
        fn_a = 4'b0111;
        sweep_a(4'b0111, 1'b0);
        fn_a = 4'b1111;
        sweep_a(4'b0111, 1'b0);

        // Delay margin
        fn_a = 4'b0111;
        dly_a = 3;
        sweep_a(4'b0111, 1'b0);
        dly_a = 4;
        sweep_a(4'b0111, 1'b0);
        dly_a = 0;

        // Start pulse and expectation change mid-run
        fn_a = 4'b0110;
        sweep_a(4'b0111, 1'b1);

        // Reset during vector 2
        fn_a = 4'b0111;
        repeat (6) @(negedge clk);
        expect_a = 4'b0111;
        start_a  = 1'b1;
        @(posedge clk);
        issue_a(4'b0111);
        @(negedge clk);
        start_a = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        tr_a.delete();
        res_a.delete();
        pend_a = 0;
        #1;
        check_zero_outputs("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sweep_a(4'b0111, 1'b0);

        // Randomised A sweeps
        for (int i = 0; i < 8; i++) begin
            fn_a = 4'($urandom);
            sweep_a(4'($urandom), 1'b0);
        end

        // Gray sweeps: matching table, then random
        fn_b = 8'b1001_0110;
        sweep_b(8'b1001_0110);
        for (int i = 0; i < 6; i++) begin
            fn_b = 8'($urandom);
            sweep_b((i == 0) ? ~fn_b : 8'($urandom));
        end

        // start held high: back-to-back sweeps with FIN and IDLE between them
        fn_b = 8'($urandom);
        expect_b = 8'($urandom);
        repeat (4) @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        issue_b(expect_b);
        tr_b.push_back('{0, 1'b0, 1'b0});
        issue_b(expect_b);
        repeat (NB * DB + 3) @(negedge clk);
        start_b = 1'b0;
        drain();

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

endmodule
